mc_fetch_datapath: RTL and testbench
====================================

// Module: mc_fetch_datapath
// PURPOSE
//   Datapath front end answering the multicycle controller: owns PC, OldPC, instruction register (IR),
//   data register, ALUOut register, Adr/Result muxes and immediate extend. Acts on the controller's
//   PCWrite/IRWrite/AdrSrc/ResultSrc/ImmSrc and returns the decoded op/funct3/funct7b5 fields.
//   Sits between the controller, unified instruction/data memory and the register file/ALU.
// PARAMETERS
//   RESET_PC   32'h0000_0000  PC and OldPC value after reset
//   NOP_INSTR  32'h0000_0013  IR value after reset (addi x0,x0,0)
// PORTS
//   clk        in   1   clock, all state updates on rising edge
//   reset      in   1   asynchronous, active-high
//   PCWrite    in   1   load PC from Result
//   IRWrite    in   1   load IR from ReadData, OldPC from PC
//   AdrSrc     in   1   0: Adr=PC, 1: Adr=Result
//   ResultSrc  in   2   00 ALUOut, 01 Data, 10 ALUResult, 11 reserved (drives 0)
//   ImmSrc     in   2   00 I, 01 S, 10 B, 11 J immediate format
//   ReadData   in   32  memory read data
//   ALUResult  in   32  combinational ALU output
//   Adr        out  32  memory address
//   PC, OldPC  out  32  program counter; PC of the instruction held in IR
//   Instr      out  32  instruction register
//   Data       out  32  data register (ReadData delayed one cycle)
//   ALUOut     out  32  ALUResult delayed one cycle
//   Result     out  32  result mux output (to PC, register file write data)
//   ImmExt     out  32  sign-extended immediate of Instr
//   op         out  7   Instr[6:0];  funct3 out 3 Instr[14:12];  funct7b5 out 1 Instr[30]
//   rs1, rs2, rd out 5  Instr[19:15], Instr[24:20], Instr[11:7]
//   InstrValid out  1   0 from reset until first IRWrite, then 1
//   FetchCount out  32  number of IRWrite cycles since reset
// BEHAVIOUR
//   - Reset (async, immediate): PC=OldPC=RESET_PC, Instr=NOP_INSTR, Data=0, ALUOut=0,
//     InstrValid=0, FetchCount=0. Combinational outputs follow the reset register values.
//   - Deassertion: first edge with reset low performs normal updates.
//   - PC: PC<=Result when PCWrite, else hold. Latency 1 cycle.
//   - IRWrite: Instr<=ReadData, OldPC<=PC (pre-update PC), InstrValid<=1, FetchCount<=FetchCount+1,
//     wraps 32'hFFFF_FFFF->0. Without IRWrite all four hold.
//   - PCWrite & IRWrite same edge (fetch): OldPC gets old PC, PC gets Result; no ordering hazard.
//   - Data<=ReadData and ALUOut<=ALUResult every cycle unconditionally (reset excepted).
//   - Adr and Result combinational from current registers/inputs; ResultSrc=11 -> Result=0.
//   - ImmExt: I {20{i31},i[31:20]}; S {20{i31},i[31:25],i[11:7]};
//     B {19{i31},i31,i7,i[30:25],i[11:8],1'b0}; J {11{i31},i31,i[19:12],i20,i[30:21],1'b0}.
//   - Decoded fields always reflect current Instr; they change only on the edge after IRWrite.
//   - X/Z on unselected mux inputs must not propagate to Adr/Result.
//   - Reset mid-instruction abandons all state; no partial writes survive.
// TESTING
//   1 reset high 22ns -> PC=0, Instr=32'h13, op=7'h13, InstrValid=0, FetchCount=0, Adr=0.
//   2 fetch: ReadData=32'h0062_E233, IRWrite=PCWrite=1, ResultSrc=10, ALUResult=4 -> next cycle
//     Instr=0062E233, OldPC=0, PC=4, op=33, funct3=6, funct7b5=0, rd=4, FetchCount=1.
//   3 AdrSrc=1, ResultSrc=00 after ALUResult=32'h60 -> Adr=60 one cycle later; Data=ReadData delayed 1.
//   4 immediates: Instr=FE42_0AE3 ImmSrc=10 -> ImmExt=FFFF_FFF4; Instr=0080_006F ImmSrc=11 -> 8;
//     Instr=FFC4_A303 ImmSrc=00 -> FFFF_FFFC; Instr=0064_A423 ImmSrc=01 -> 8.
//   5 PCWrite=0, IRWrite=0 for 5 cycles with changing ReadData -> PC/Instr/OldPC hold, Data tracks.
//   6 reset asserted mid-cycle after 3 fetches -> immediate PC=RESET_PC, FetchCount=0, InstrValid=0.

Source files
------------

// File: rtl/mc_fetch_datapath.sv
`default_nettype none
// ============================================================================
//  Module      : mc_fetch_datapath
//  Description : Datapath front end for the multicycle controller. Holds
//                PC, OldPC, IR, data and ALUOut registers. Provides the
//                Adr and Result muxes, the immediate extender and the
//                decoded instruction fields that go back to the controller.
//  Ports       : clk, reset          - clock, async active-high reset
//                PCWrite, IRWrite    - register load enables from controller
//                AdrSrc, ResultSrc   - address / result mux selects
//                ImmSrc              - immediate format (I/S/B/J)
//                ReadData, ALUResult - memory read data, ALU output
//                Adr, PC, OldPC, Instr, Data, ALUOut, Result, ImmExt
//                op, funct3, funct7b5, rs1, rs2, rd - decoded fields
//                InstrValid, FetchCount - fetch status
//  Revision    : 1.0 - initial release
// ============================================================================
module mc_fetch_datapath #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PCWrite,
  input  logic        IRWrite,
  input  logic        AdrSrc,
  input  logic [1:0]  ResultSrc,
  input  logic [1:0]  ImmSrc,
  input  logic [31:0] ReadData,
  input  logic [31:0] ALUResult,
  output logic [31:0] Adr,
  output logic [31:0] PC,
  output logic [31:0] OldPC,
  output logic [31:0] Instr,
  output logic [31:0] Data,
  output logic [31:0] ALUOut,
  output logic [31:0] Result,
  output logic [31:0] ImmExt,
  output logic [6:0]  op,
  output logic [2:0]  funct3,
  output logic        funct7b5,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic        InstrValid,
  output logic [31:0] FetchCount
);

  localparam logic [1:0] c_RES_ALUOUT = 2'b00;
  localparam logic [1:0] c_RES_DATA   = 2'b01;
  localparam logic [1:0] c_RES_ALURES = 2'b10;

  localparam logic [1:0] c_IMM_I = 2'b00;
  localparam logic [1:0] c_IMM_S = 2'b01;
  localparam logic [1:0] c_IMM_B = 2'b10;

  logic [31:0] r_pc;
  logic [31:0] r_old_pc;
  logic [31:0] r_instr;
  logic [31:0] r_data;
  logic [31:0] r_alu_out;
  logic        r_instr_valid;
  logic [31:0] r_fetch_count;

  logic [31:0] w_result;
  logic [31:0] w_imm_ext;

  // OldPC samples the pre-update PC on the same edge PC may be reloaded,
  // so a combined fetch (PCWrite & IRWrite) captures the fetched
  // instruction's own address.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc          <= RESET_PC;
      r_old_pc      <= RESET_PC;
      r_instr       <= NOP_INSTR;
      r_data        <= 32'h0;
      r_alu_out     <= 32'h0;
      r_instr_valid <= 1'b0;
      r_fetch_count <= 32'h0;
    end else begin
      r_data    <= ReadData;
      r_alu_out <= ALUResult;
      if (PCWrite) begin
        r_pc <= w_result;
      end
      if (IRWrite) begin
        r_instr       <= ReadData;
        r_old_pc      <= r_pc;
        r_instr_valid <= 1'b1;
        r_fetch_count <= r_fetch_count + 32'd1;
      end
    end
  end

  // Case-based mux: unselected inputs never reach the output, and the
  // reserved select drives zero.
  always_comb begin
    w_result = 32'h0;
    case (ResultSrc)
      c_RES_ALUOUT: w_result = r_alu_out;
      c_RES_DATA:   w_result = r_data;
      c_RES_ALURES: w_result = ALUResult;
      default:      w_result = 32'h0;
    endcase
  end

  always_comb begin
    w_imm_ext = 32'h0;
    case (ImmSrc)
      c_IMM_I: w_imm_ext = {{20{r_instr[31]}}, r_instr[31:20]};
      c_IMM_S: w_imm_ext = {{20{r_instr[31]}}, r_instr[31:25], r_instr[11:7]};
      c_IMM_B: w_imm_ext = {{19{r_instr[31]}}, r_instr[31], r_instr[7],
                            r_instr[30:25], r_instr[11:8], 1'b0};
      default: w_imm_ext = {{11{r_instr[31]}}, r_instr[31], r_instr[19:12],
                            r_instr[20], r_instr[30:21], 1'b0};
    endcase
  end

  assign Adr        = AdrSrc ? w_result : r_pc;
  assign Result     = w_result;
  assign ImmExt     = w_imm_ext;
  assign PC         = r_pc;
  assign OldPC      = r_old_pc;
  assign Instr      = r_instr;
  assign Data       = r_data;
  assign ALUOut     = r_alu_out;
  assign InstrValid = r_instr_valid;
  assign FetchCount = r_fetch_count;

  assign op       = r_instr[6:0];
  assign funct3   = r_instr[14:12];
  assign funct7b5 = r_instr[30];
  assign rs1      = r_instr[19:15];
  assign rs2      = r_instr[24:20];
  assign rd       = r_instr[11:7];

endmodule
`default_nettype wire

// File: tb/tb_mc_fetch_datapath.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mc_fetch_datapath
//  Description : Directed self-checking bench for mc_fetch_datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mc_fetch_datapath;

  logic        clk = 1'b0;
  logic        reset;
  logic        PCWrite, IRWrite, AdrSrc;
  logic [1:0]  ResultSrc, ImmSrc;
  logic [31:0] ReadData, ALUResult;
  logic [31:0] Adr, PC, OldPC, Instr, Data, ALUOut, Result, ImmExt, FetchCount;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        funct7b5, InstrValid;
  logic [4:0]  rs1, rs2, rd;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_pc;

  mc_fetch_datapath dut (
    .clk(clk), .reset(reset), .PCWrite(PCWrite), .IRWrite(IRWrite),
    .AdrSrc(AdrSrc), .ResultSrc(ResultSrc), .ImmSrc(ImmSrc),
    .ReadData(ReadData), .ALUResult(ALUResult), .Adr(Adr), .PC(PC),
    .OldPC(OldPC), .Instr(Instr), .Data(Data), .ALUOut(ALUOut),
    .Result(Result), .ImmExt(ImmExt), .op(op), .funct3(funct3),
    .funct7b5(funct7b5), .rs1(rs1), .rs2(rs2), .rd(rd),
    .InstrValid(InstrValid), .FetchCount(FetchCount)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; PCWrite = 1'b0; IRWrite = 1'b0; AdrSrc = 1'b0;
    ResultSrc = 2'b00; ImmSrc = 2'b00; ReadData = 32'h0; ALUResult = 32'h0;

    // 1: reset state
    #20;
    chk("rst_pc", PC, 32'h0);
    chk("rst_oldpc", OldPC, 32'h0);
    chk("rst_instr", Instr, 32'h13);
    chk("rst_op", {25'h0, op}, 32'h13);
    chk("rst_valid", {31'h0, InstrValid}, 32'h0);
    chk("rst_fcnt", FetchCount, 32'h0);
    chk("rst_adr", Adr, 32'h0);
    chk("rst_data", Data, 32'h0);
    chk("rst_aluout", ALUOut, 32'h0);
    #2 reset = 1'b0;

    // 2: combined fetch
    ReadData = 32'h0062_E233; IRWrite = 1'b1; PCWrite = 1'b1;
    ResultSrc = 2'b10; ALUResult = 32'h4;
    #1;
    chk("res_alures", Result, 32'h4);
    step();
    IRWrite = 1'b0; PCWrite = 1'b0;
    chk("f_instr", Instr, 32'h0062_E233);
    chk("f_oldpc", OldPC, 32'h0);
    chk("f_pc", PC, 32'h4);
    chk("f_op", {25'h0, op}, 32'h33);
    chk("f_funct3", {29'h0, funct3}, 32'h6);
    chk("f_f7b5", {31'h0, funct7b5}, 32'h0);
    chk("f_rd", {27'h0, rd}, 32'h4);
    chk("f_rs1", {27'h0, rs1}, 32'h5);
    chk("f_rs2", {27'h0, rs2}, 32'h6);
    chk("f_fcnt", FetchCount, 32'h1);
    chk("f_valid", {31'h0, InstrValid}, 32'h1);
    chk("f_data", Data, 32'h0062_E233);
    chk("f_aluout", ALUOut, 32'h4);

    // 3: address from ALUOut, one-cycle latency; result mux selects
    ALUResult = 32'h60; ResultSrc = 2'b00; AdrSrc = 1'b1; ReadData = 32'hAABB_CCDD;
    #1;
    chk("adr_before", Adr, 32'h4);
    step();
    chk("adr_after", Adr, 32'h60);
    chk("data_dly", Data, 32'hAABB_CCDD);
    ResultSrc = 2'b01; #1;
    chk("res_data", Result, 32'hAABB_CCDD);
    chk("adr_data", Adr, 32'hAABB_CCDD);
    ResultSrc = 2'b11; ALUResult = 32'hxxxx_xxxx; #1;
    chk("res_rsvd", Result, 32'h0);
    ResultSrc = 2'b00; #1;
    chk("res_noX", Result, 32'h60);
    AdrSrc = 1'b0; #1;
    chk("adr_pc", Adr, 32'h4);
    ALUResult = 32'h0;

    // 4: immediates
    IRWrite = 1'b1; ReadData = 32'hFE42_0AE3; step();
    IRWrite = 1'b0;
    ImmSrc = 2'b10; #1; chk("imm_b", ImmExt, 32'hFFFF_FFF4);
    ImmSrc = 2'b00; #1; chk("imm_b_as_i", ImmExt, 32'hFFFF_FFE4);
    IRWrite = 1'b1; ReadData = 32'h0080_006F; step();
    IRWrite = 1'b0;
    ImmSrc = 2'b11; #1; chk("imm_j", ImmExt, 32'h8);
    IRWrite = 1'b1; ReadData = 32'hFFC4_A303; step();
    IRWrite = 1'b0;
    ImmSrc = 2'b00; #1; chk("imm_i", ImmExt, 32'hFFFF_FFFC);
    IRWrite = 1'b1; ReadData = 32'h0064_A423; step();
    IRWrite = 1'b0;
    ImmSrc = 2'b01; #1; chk("imm_s", ImmExt, 32'h8);
    chk("imm_fcnt", FetchCount, 32'h5);
    chk("imm_oldpc", OldPC, 32'h4);

    // 5: hold with changing ReadData
    for (int i = 0; i < 5; i++) begin
      ReadData = 32'h1000 + 32'(i);
      step();
      chk("hold_pc", PC, 32'h4);
      chk("hold_instr", Instr, 32'h0064_A423);
      chk("hold_oldpc", OldPC, 32'h4);
      chk("hold_data", Data, 32'h1000 + 32'(i));
    end
    chk("hold_fcnt", FetchCount, 32'h5);

    // 6: three fetches then asynchronous reset mid-cycle
    exp_pc = 32'h4;
    ResultSrc = 2'b10; PCWrite = 1'b1; IRWrite = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ALUResult = exp_pc + 32'h4;
      ReadData  = 32'h0000_0093 + (32'(i) << 20);
      step();
      chk("seq_oldpc", OldPC, exp_pc);
      exp_pc = exp_pc + 32'h4;
      chk("seq_pc", PC, exp_pc);
      chk("seq_instr", Instr, 32'h0000_0093 + (32'(i) << 20));
    end
    chk("seq_fcnt", FetchCount, 32'h8);
    PCWrite = 1'b0; IRWrite = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("mid_pc", PC, 32'h0);
    chk("mid_oldpc", OldPC, 32'h0);
    chk("mid_instr", Instr, 32'h13);
    chk("mid_fcnt", FetchCount, 32'h0);
    chk("mid_valid", {31'h0, InstrValid}, 32'h0);
    chk("mid_aluout", ALUOut, 32'h0);
    step();
    reset = 1'b0;

    // fetch after reset restarts counting
    PCWrite = 1'b1; IRWrite = 1'b1; ALUResult = 32'h4; ReadData = 32'h0010_0093;
    step();
    PCWrite = 1'b0; IRWrite = 1'b0;
    chk("post_fcnt", FetchCount, 32'h1);
    chk("post_pc", PC, 32'h4);
    chk("post_oldpc", OldPC, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
